// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, cause codes, write masks and shared types
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] CAUSE_ECALL_U       = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;
  localparam logic [3:0] IRQ_SOFT            = 4'd3;
  localparam logic [3:0] IRQ_TIMER           = 4'd7;
  localparam logic [3:0] IRQ_EXT             = 4'd11;

  localparam logic [12:0] MSTATUS_WMASK = 13'h1888;
  localparam logic [11:0] MIE_WMASK     = 12'h888;
  localparam logic [11:0] IRQ_MASK      = 12'h888;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    MODE_U = 2'b00,
    MODE_M = 2'b11
  } mode_t;

endpackage

// File: rtl/csr_unit_m_if.sv
// rtl/csr_unit_m_if.sv - commit/CSR/trap bus between the core writeback stage and the CSR unit
interface csr_unit_m_if #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 6
);
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic [1:0]        csr_op;
  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic              illegal_csr;
  logic              exc_valid;
  logic [CAUSE_W-1:0] exc_code;
  logic [XLEN-1:0]   exc_tval;
  logic              ecall;
  logic              mret;
  logic              irq_timer;
  logic              irq_soft;
  logic              irq_ext;
  logic              int_pending;
  logic              int_accept;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [1:0]        pmode;

  modport master (
    output commit_valid, commit_pc, csr_op, csr_addr, csr_wdata,
           exc_valid, exc_code, exc_tval, ecall, mret,
           irq_timer, irq_soft, irq_ext, int_accept,
    input  csr_rdata, illegal_csr, int_pending, redirect_valid, redirect_pc, pmode
  );

  modport slave (
    input  commit_valid, commit_pc, csr_op, csr_addr, csr_wdata,
           exc_valid, exc_code, exc_tval, ecall, mret,
           irq_timer, irq_soft, irq_ext, int_accept,
    output csr_rdata, illegal_csr, int_pending, redirect_valid, redirect_pc, pmode
  );
endinterface

// File: rtl/csr_irq_arbiter.sv
// rtl/csr_irq_arbiter.sv - picks the winning enabled interrupt (ext > soft > timer)
module csr_irq_arbiter
  import csr_pkg::*;
(
  input  logic [11:0] mip_i,
  input  logic [11:0] mie_i,
  input  logic        mstatus_mie_i,
  input  mode_t       pmode_i,
  output logic        int_pending_o,
  output logic [3:0]  int_code_o
);

  logic [11:0] pend;

  assign pend          = mip_i & mie_i & IRQ_MASK;
  // U-mode code is always interruptible by M-mode interrupts
  assign int_pending_o = (|pend) && (pmode_i == MODE_U || mstatus_mie_i);

  always_comb begin
    int_code_o = 4'd0;
    if (pend[11])     int_code_o = IRQ_EXT;
    else if (pend[3]) int_code_o = IRQ_SOFT;
    else if (pend[7]) int_code_o = IRQ_TIMER;
  end

endmodule

// File: rtl/csr_unit_m.sv
// rtl/csr_unit_m.sv - M/U CSR file with trap entry, mret and registered fetch redirect
// Optional vectored interrupt dispatch through mtvec.MODE: CSR_VECTORED_TRAP_EN
module csr_unit_m
  import csr_pkg::*;
#(
  parameter int          XLEN    = 64,
  parameter int unsigned HARTID  = 0,
  parameter int          CAUSE_W = 6
) (
  input logic        clk_i,
  input logic        rst_i,
  csr_unit_m_if.slave bus
);

  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d, mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [11:0]     mip_q, mip_d;
  mode_t           pmode_q, pmode_d;
  logic            redirect_valid_q, redirect_valid_d;

  csr_op_t         op;
  logic [XLEN-1:0] rdata, wval, mstatus_new, trap_pc;
  logic            hit, writes, illegal, int_pending;
  logic [3:0]      int_code;
  logic            take_int, take_exc, take_ecall, mret_ev, mret_u, trap, csr_we;

  assign op = csr_op_t'(bus.csr_op);

  csr_irq_arbiter u_arb (
    .mip_i         (mip_q),
    .mie_i         (mie_q[11:0]),
    .mstatus_mie_i (mstatus_q[MSTATUS_MIE]),
    .pmode_i       (pmode_q),
    .int_pending_o (int_pending),
    .int_code_o    (int_code)
  );

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:  rdata = mstatus_q;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = XLEN'(mip_q);
      CSR_MCYCLE:   rdata = mcycle_q;
      CSR_MINSTRET: rdata = minstret_q;
      CSR_MHARTID:  rdata = XLEN'(HARTID);
      default:      hit   = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so read-only addresses stay legal
  assign writes  = (op == CSR_OP_RW) || (bus.csr_wdata != '0);
  assign illegal = bus.commit_valid && (op != CSR_OP_NONE) &&
                   (!hit || (writes && bus.csr_addr[11:10] == 2'b11) || pmode_q == MODE_U);

  always_comb begin
    case (op)
      CSR_OP_RW: wval = bus.csr_wdata;
      CSR_OP_RS: wval = rdata | bus.csr_wdata;
      CSR_OP_RC: wval = rdata & ~bus.csr_wdata;
      default:   wval = rdata;
    endcase
    mstatus_new = (mstatus_q & ~XLEN'(MSTATUS_WMASK)) | (wval & XLEN'(MSTATUS_WMASK));
    if (mstatus_new[12:11] == 2'b01 || mstatus_new[12:11] == 2'b10)
      mstatus_new[12:11] = 2'b00;
  end

  assign take_int   = bus.int_accept;
  assign take_exc   = !take_int && bus.commit_valid && bus.exc_valid;
  assign take_ecall = !take_int && !take_exc && bus.commit_valid && bus.ecall;
  assign mret_ev    = !take_int && !take_exc && !take_ecall && bus.commit_valid && bus.mret;
  assign mret_u     = mret_ev && (pmode_q == MODE_U);
  assign trap       = take_int || take_exc || take_ecall || mret_u;
  assign csr_we     = !trap && !mret_ev && bus.commit_valid && (op != CSR_OP_NONE) &&
                      !illegal && writes;

  always_comb begin
    trap_pc = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_TRAP_EN
    if (take_int && mtvec_q[0])
      trap_pc = trap_pc + XLEN'({int_code, 2'b00});
`endif
  end

  always_comb begin
    mstatus_d        = mstatus_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    pmode_d          = pmode_q;
    mip_d            = 12'd0;
    mip_d[11]        = bus.irq_ext;
    mip_d[3]         = bus.irq_soft;
    mip_d[7]         = bus.irq_timer;
    mcycle_d         = mcycle_q + 1'b1;
    minstret_d       = minstret_q + XLEN'(bus.commit_valid && !trap && !illegal);
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (trap) begin
      mepc_d = {bus.commit_pc[XLEN-1:2], 2'b00};
      if (take_int)        mcause_d = {1'b1, {(XLEN-5){1'b0}}, int_code};
      else if (take_exc)   mcause_d = XLEN'(bus.exc_code);
      else if (take_ecall) mcause_d = XLEN'((pmode_q == MODE_U) ? CAUSE_ECALL_U : CAUSE_ECALL_M);
      else                 mcause_d = XLEN'(CAUSE_ILLEGAL_INSTR);
      mtval_d = take_exc ? bus.exc_tval : '0;
      mstatus_d[MSTATUS_MPIE]                = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                 = 1'b0;
      mstatus_d[MSTATUS_MPP+1:MSTATUS_MPP]   = pmode_q;
      pmode_d          = MODE_M;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_pc;
    end else if (mret_ev) begin
      mstatus_d[MSTATUS_MIE]                 = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]                = 1'b1;
      mstatus_d[MSTATUS_MPP+1:MSTATUS_MPP]   = 2'b00;
      pmode_d          = mode_t'(mstatus_q[MSTATUS_MPP+1:MSTATUS_MPP]);
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS:  mstatus_d  = mstatus_new;
        CSR_MIE:      mie_d      = wval & XLEN'(MIE_WMASK);
`ifdef CSR_VECTORED_TRAP_EN
        CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
`else
        CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], 2'b00};
`endif
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        CSR_MCYCLE:   mcycle_d   = wval;
        CSR_MINSTRET: minstret_d = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_q        <= '0;
      mie_q            <= '0;
      mtvec_q          <= '0;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mcycle_q         <= '0;
      minstret_q       <= '0;
      mip_q            <= '0;
      pmode_q          <= MODE_M;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mstatus_q        <= mstatus_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mcycle_q         <= mcycle_d;
      minstret_q       <= minstret_d;
      mip_q            <= mip_d;
      pmode_q          <= pmode_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.csr_rdata      = rdata;
  assign bus.illegal_csr    = illegal;
  assign bus.int_pending    = int_pending;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.pmode          = pmode_q;

endmodule

// File: tb/tb_csr_unit_m.sv
// tb/tb_csr_unit_m.sv - directed self-checking bench for csr_unit_m
module tb_csr_unit_m;
  import csr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  csr_unit_m_if #(.XLEN(64), .CAUSE_W(6)) bus ();

  csr_unit_m #(.XLEN(64), .HARTID(5), .CAUSE_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.commit_valid = 1'b0;
    bus.csr_op       = 2'd0;
    bus.csr_wdata    = '0;
    bus.exc_valid    = 1'b0;
    bus.exc_code     = '0;
    bus.exc_tval     = '0;
    bus.ecall        = 1'b0;
    bus.mret         = 1'b0;
    bus.int_accept   = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wdata);
    bus.commit_valid = 1'b1;
    bus.csr_op       = op;
    bus.csr_addr     = addr;
    bus.csr_wdata    = wdata;
    cyc();
    clear();
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    bus.csr_addr = addr;
    #1;
    check(tag, bus.csr_rdata, exp);
  endtask

  task automatic retire(input logic [63:0] pc, input logic is_ecall, input logic is_mret);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.ecall        = is_ecall;
    bus.mret         = is_mret;
    cyc();
    clear();
  endtask

  initial begin
    clear();
    bus.commit_pc = '0;
    bus.csr_addr  = '0;
    bus.irq_timer = 1'b0;
    bus.irq_soft  = 1'b0;
    bus.irq_ext   = 1'b0;

    // reset state and free-running mcycle
    rst = 1'b1;
    repeat (2) cyc();
    check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    check("rst_pmode", 64'(bus.pmode), 64'd3);
    chk_csr("mhartid", CSR_MHARTID, 64'd5);
    chk_csr("rst_mcycle", CSR_MCYCLE, 64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk_csr($sformatf("mcycle_%0d", i), CSR_MCYCLE, 64'(i));
    end

    // ecall from M-mode
    csr(2'd1, CSR_MTVEC, 64'h8000_0100);
    retire(64'h8000_0040, 1'b1, 1'b0);
    check("ecall_m_redirect", 64'(bus.redirect_valid), 64'd1);
    check("ecall_m_redirect_pc", bus.redirect_pc, 64'h8000_0100);
    chk_csr("ecall_m_mepc", CSR_MEPC, 64'h8000_0040);
    chk_csr("ecall_m_mcause", CSR_MCAUSE, 64'd11);
    chk_csr("ecall_m_mstatus", CSR_MSTATUS, 64'h1800);
    cyc();
    check("redirect_one_pulse", 64'(bus.redirect_valid), 64'd0);

    // mret into U-mode, then ecall from U
    csr(2'd3, CSR_MSTATUS, 64'h1800);
    retire(64'h0, 1'b0, 1'b1);
    check("mret_pmode", 64'(bus.pmode), 64'd0);
    check("mret_redirect", 64'(bus.redirect_valid), 64'd1);
    check("mret_redirect_pc", bus.redirect_pc, 64'h8000_0040);
    chk_csr("mret_mstatus", CSR_MSTATUS, 64'h80);
    retire(64'h1234_5677, 1'b1, 1'b0);
    chk_csr("ecall_u_mcause", CSR_MCAUSE, 64'd8);
    chk_csr("ecall_u_mepc", CSR_MEPC, 64'h1234_5674);
    chk_csr("ecall_u_mstatus", CSR_MSTATUS, 64'h0);
    check("ecall_u_pmode", 64'(bus.pmode), 64'd3);

    // interrupts: timer pending after one cycle, ext wins arbitration on accept
    csr(2'd1, CSR_MIE, 64'h80);
    csr(2'd2, CSR_MSTATUS, 64'h8);
    bus.irq_timer = 1'b1;
    #1;
    check("int_pending_latency", 64'(bus.int_pending), 64'd0);
    cyc();
    check("int_pending_timer", 64'(bus.int_pending), 64'd1);
    csr(2'd1, CSR_MIE, 64'h880);
    bus.irq_ext = 1'b1;
    cyc();
    bus.int_accept = 1'b1;
    bus.commit_pc  = 64'h8000_0200;
    cyc();
    clear();
    bus.irq_timer = 1'b0;
    bus.irq_ext   = 1'b0;
    chk_csr("int_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    chk_csr("int_mepc", CSR_MEPC, 64'h8000_0200);
    chk_csr("int_mstatus", CSR_MSTATUS, 64'h1880);
    check("int_redirect_pc", bus.redirect_pc, 64'h8000_0100);
    check("int_pending_masked", 64'(bus.int_pending), 64'd0);

    // counter writes win over increment; mcycle wraps
    csr(2'd1, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_csr("mcycle_written", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    chk_csr("mcycle_wrap", CSR_MCYCLE, 64'd0);
    csr(2'd1, CSR_MINSTRET, 64'd100);
    retire(64'h0, 1'b0, 1'b0);
    retire(64'h0, 1'b0, 1'b0);
    chk_csr("minstret", CSR_MINSTRET, 64'd102);

    // RS/RC on mstatus with MPP legalisation, mip write ignored, illegal detection
    csr(2'd3, CSR_MSTATUS, 64'h1800);
    csr(2'd2, CSR_MSTATUS, 64'h1800);
    chk_csr("mpp_set_m", CSR_MSTATUS, 64'h1880);
    csr(2'd3, CSR_MSTATUS, 64'h1800);
    csr(2'd2, CSR_MSTATUS, 64'h0800);
    chk_csr("mpp_legalised", CSR_MSTATUS, 64'h80);
    csr(2'd1, CSR_MIP, 64'hFFF);
    chk_csr("mip_ro", CSR_MIP, 64'h0);
    bus.commit_valid = 1'b1;
    bus.csr_op = 2'd1; bus.csr_addr = CSR_MHARTID; bus.csr_wdata = 64'd1;
    #1;
    check("illegal_ro_write", 64'(bus.illegal_csr), 64'd1);
    bus.csr_op = 2'd2; bus.csr_wdata = 64'd0;
    #1;
    check("legal_ro_read_rs0", 64'(bus.illegal_csr), 64'd0);
    bus.csr_op = 2'd1; bus.csr_addr = 12'h7C0; bus.csr_wdata = 64'd1;
    #1;
    check("illegal_unimpl", 64'(bus.illegal_csr), 64'd1);
    clear();
    retire(64'h0, 1'b0, 1'b1);
    check("mret2_pmode", 64'(bus.pmode), 64'd0);
    check("mret2_redirect_pc", bus.redirect_pc, 64'h8000_0200);
    bus.commit_valid = 1'b1;
    bus.csr_op = 2'd3; bus.csr_addr = CSR_MIE; bus.csr_wdata = 64'd0;
    #1;
    check("illegal_u_mode", 64'(bus.illegal_csr), 64'd1);
    cyc();
    clear();
    chk_csr("mie_unchanged", CSR_MIE, 64'h880);

    // exc_valid beats ecall; back-to-back traps; reset drops a pending redirect
    bus.commit_valid = 1'b1;
    bus.commit_pc = 64'h4000; bus.exc_valid = 1'b1; bus.exc_code = 6'd5;
    bus.exc_tval = 64'hDEAD; bus.ecall = 1'b1;
    cyc();
    bus.exc_valid = 1'b0; bus.exc_tval = '0; bus.commit_pc = 64'h4004;
    check("exc_redirect", 64'(bus.redirect_valid), 64'd1);
    chk_csr("exc_mcause", CSR_MCAUSE, 64'd5);
    chk_csr("exc_mtval", CSR_MTVAL, 64'hDEAD);
    chk_csr("exc_mepc", CSR_MEPC, 64'h4000);
    cyc();
    check("b2b_redirect", 64'(bus.redirect_valid), 64'd1);
    chk_csr("b2b_mcause", CSR_MCAUSE, 64'd11);
    chk_csr("b2b_mepc", CSR_MEPC, 64'h4004);
    chk_csr("b2b_mtval", CSR_MTVAL, 64'd0);
    rst = 1'b1;
    cyc();
    check("rst_drop_redirect", 64'(bus.redirect_valid), 64'd0);
    chk_csr("rst_mcause", CSR_MCAUSE, 64'd0);
    check("rst_pmode2", 64'(bus.pmode), 64'd3);
    rst = 1'b0;
    clear();
    cyc();
    check("post_rst_redirect", 64'(bus.redirect_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
